// File: rtl/lane_pkg.sv
// Shared lane-bus types and helpers for the X/Z scrubber.
package lane_pkg;
  localparam int LANES  = 4;
  localparam int LANE_W = 5;

  typedef bit   [1:LANES][LANE_W-1:0] lane_word_t;
  typedef logic [1:LANES][LANE_W-1:0] lane_word4_t;

  typedef struct packed {
    lane_word_t data;
    lane_word_t mask;
  } scrub_entry_t;

  function automatic logic [4:0] popcount20(input lane_word_t m);
    bit [LANES*LANE_W-1:0] flat;
    logic [4:0] cnt;
    flat = m;
    cnt  = '0;
    for (int i = 0; i < LANES*LANE_W; i++) begin
      cnt = cnt + 5'(flat[i]);
    end
    return cnt;
  endfunction
endpackage

// File: rtl/lane_xz_scrubber_if.sv
// Input/output valid-ready lane bus of the scrubber; slave is the scrubber side.
interface lane_xz_scrubber_if;
  import lane_pkg::*;

  lane_word4_t in_data;
  logic        in_valid;
  logic        in_ready;
  lane_word_t  out_data;
  lane_word_t  out_xz_mask;
  logic        out_valid;
  logic        out_ready;

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_xz_mask, out_valid
  );

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_xz_mask, out_valid
  );
endinterface

// File: rtl/lane_sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers; head reads as zero while empty.
module lane_sync_fifo
  import lane_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = scrub_entry_t
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   push_i,
  input  entry_t wdata_i,
  input  logic   pop_i,
  output entry_t rdata_o,
  output logic   full_o,
  output logic   empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [AW:0] wptr_q, rptr_q;
  entry_t      mem_q [DEPTH];

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign rdata_o = empty_o ? '0 : mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push_i && !full_o) wptr_q <= wptr_q + PTR_ONE;
      if (pop_i && !empty_o) rptr_q <= rptr_q + PTR_ONE;
    end
  end

  // Storage needs no reset: stale entries are unreachable once pointers are cleared.
  always_ff @(posedge clk) begin
    if (push_i && !full_o) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end
endmodule

// File: rtl/lane_xz_scrubber.sv
// Replaces X/Z bits of incoming lane words with a 2-state fill, queues the
// scrubbed words with their X/Z mask, and counts X/Z occurrences.
module lane_xz_scrubber
  import lane_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter bit XZ_FILL = 1'b0,
  parameter int CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  lane_xz_scrubber_if.slave    bus,
  output logic [CNT_W-1:0]     xz_words,
  output logic [CNT_W-1:0]     xz_bits,
  output logic                 xz_seen
);
  localparam int SW = ((CNT_W > 5) ? CNT_W : 5) + 1;
  localparam logic [CNT_W-1:0] CMAX = {CNT_W{1'b1}};

  scrub_entry_t     scrubbed, head;
  logic             full, empty, accept, pop;
  logic [CNT_W-1:0] xz_words_q, xz_words_d, xz_bits_q, xz_bits_d;
  logic             xz_seen_q, xz_seen_d;
  logic [SW-1:0]    bits_sum;

  always_comb begin
    scrubbed = '0;
    for (int l = 1; l <= LANES; l++) begin
      for (int b = 0; b < LANE_W; b++) begin
        if ($isunknown(bus.in_data[l][b])) begin
          scrubbed.data[l][b] = XZ_FILL;
          scrubbed.mask[l][b] = 1'b1;
        end else begin
          scrubbed.data[l][b] = bus.in_data[l][b];
        end
      end
    end
  end

  // rst_n gating keeps in_ready low for the whole reset pulse.
  assign bus.in_ready = rst_n && !full;
  assign accept       = (bus.in_valid === 1'b1) && bus.in_ready;
  assign pop          = !empty && bus.out_ready;

  lane_sync_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (scrub_entry_t)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (accept),
    .wdata_i (scrubbed),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty)
  );

  assign bus.out_valid   = !empty;
  assign bus.out_data    = head.data;
  assign bus.out_xz_mask = head.mask;

  always_comb begin
    bits_sum   = SW'(xz_bits_q) + SW'(popcount20(scrubbed.mask));
    xz_bits_d  = (bits_sum > SW'(CMAX)) ? CMAX : CNT_W'(bits_sum);
    xz_words_d = xz_words_q;
    if ((scrubbed.mask != '0) && (xz_words_q != CMAX)) xz_words_d = xz_words_q + CNT_W'(1);
    xz_seen_d  = xz_seen_q || (scrubbed.mask != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xz_words_q <= '0;
      xz_bits_q  <= '0;
      xz_seen_q  <= 1'b0;
    end else if (accept) begin
      xz_words_q <= xz_words_d;
      xz_bits_q  <= xz_bits_d;
      xz_seen_q  <= xz_seen_d;
    end
  end

  assign xz_words = xz_words_q;
  assign xz_bits  = xz_bits_q;
  assign xz_seen  = xz_seen_q;
endmodule
